// File: rtl/gonso_wb_pkg.sv
// Shared definitions for the gonso Wishbone initiator: FSM encodings,
// register window addresses and bus widths.
package gonso_wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    localparam int WB_SW = WB_DW / 8;

    localparam logic [WB_AW-1:0] GONSO_REG       = 32'h3003_0004;
    localparam logic [WB_AW-1:0] GONSO_PLUS_REG  = 32'h3003_0008;
    localparam logic [WB_AW-1:0] GONSO_COLOR_REG = 32'h3003_000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/gonso_wb_timeout.sv
// Bus-cycle watchdog: a loadable down-counter that flags the last permitted
// strobe cycle. Loaded when a command is accepted and enabled while the bus
// is active. TIMEOUT_CYCLES = 0 disables expiry entirely.
module gonso_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on a new command, otherwise count down while the bus waits.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is the cycle in which the count has reached zero while waiting.
    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/gonso_wb_initiator.sv
// Wishbone classic-cycle master for the gonso register window. Takes one
// command at a time, runs a single cyc/stb cycle until ack or timeout, and
// presents the result on a response port. Every output is a register.
//
// Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
// a response transfers on an edge where rsp_valid && rsp_ready. cmd_valid must
// be held until accepted; rsp_* are held until consumed.
module gonso_wb_initiator
    import gonso_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [WB_AW-1:0]     cmd_addr,
    input  logic [WB_DW-1:0]     cmd_wdata,
    input  logic [WB_SW-1:0]     cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DW-1:0]     rsp_rdata,
    output logic                 rsp_err,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_SW-1:0]     wbm_sel_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           dbg_state_o
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    wb_state_e            state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [WB_AW-1:0]     adr_q, adr_d;
    logic [WB_DW-1:0]     dat_q, dat_d;
    logic [WB_SW-1:0]     sel_q, sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_expire;

    gonso_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d     = ST_BUS;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we;
                    adr_d       = cmd_addr;
                    dat_d       = cmd_wdata;
                    sel_d       = cmd_sel;
                    tmr_load    = 1'b1;
                end
            end
            ST_BUS: begin
                tmr_en = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (wbm_ack_i || tmr_expire) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wbm_ack_i;
                    rsp_rdata_d = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
                    if (!wbm_ack_i && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_ONE;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, bus and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign err_count   = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gonso_wb_initiator.sv
// Directed bench for gonso_wb_initiator: the DUT drives a gonso register
// responder with programmable ack latency (0 = never ack) plus an injectable
// stray ack. Outputs are sampled on the falling clock edge.
module tb_gonso_wb_initiator;
  import gonso_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  gonso_wb_initiator #(.TIMEOUT_CYCLES(16), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .err_count(err_count), .dbg_state_o(dbg_state)
  );

  // ---------------- gonso responder model ----------------
  int          slv_lat = 2;
  int          slv_cnt = 0;
  logic        model_ack;
  logic        stray_ack = 1'b0;
  logic [31:0] m_gonso = '0;
  logic [31:0] m_plus = '0;
  logic [7:0]  m_color = '0;
  int          stb_total = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  assign model_ack = wbm_cyc_o && wbm_stb_o && (slv_lat != 0) && (slv_cnt == slv_lat - 1);
  assign wbm_ack_i = model_ack | stray_ack;

  always_comb begin
    wbm_dat_i = 32'h0;
    if (wbm_adr_o == GONSO_REG) wbm_dat_i = m_gonso;
    else if (wbm_adr_o == GONSO_PLUS_REG) wbm_dat_i = m_plus;
    else if (wbm_adr_o == GONSO_COLOR_REG) wbm_dat_i = {24'h0, m_color};
  end

  always @(posedge clk) begin
    if (wbm_stb_o) stb_total <= stb_total + 1;
    if (wbm_cyc_o && !model_ack) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
    if (model_ack && wbm_we_o) begin
      if (wbm_adr_o == GONSO_REG) m_gonso <= merge(m_gonso, wbm_dat_o, wbm_sel_o);
      else if (wbm_adr_o == GONSO_PLUS_REG) m_plus <= merge(m_plus, wbm_dat_o, wbm_sel_o);
      else if (wbm_adr_o == GONSO_COLOR_REG && wbm_sel_o[0]) m_color <= wbm_dat_o[7:0];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offer a command at a falling edge; returns at the falling edge of the first bus cycle.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel);
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid; k = falling-edge index after the accept edge where it is seen.
  task automatic wait_rsp(input int budget, output int k);
    k = 1;
    while (!rsp_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_valid_wait", {31'h0, rsp_valid}, 32'h1);
  endtask

  // One full transaction with rsp_ready high; returns after the response cycle.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel, output logic [31:0] rd, output logic er,
                      output int k);
    send(we, addr, wdata, sel);
    wait_rsp(40, k);
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          k;
    int          s0;
    logic [31:0] hold_rd;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_err_count", {24'h0, err_count}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Write with ack one cycle after strobe
    slv_lat = 2;
    s0 = stb_total;
    send(1'b1, 32'h3003_0004, 32'h0001_2345, 4'hF);
    chk("t1_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    chk("t1_stb", {31'h0, wbm_stb_o}, 32'h1);
    chk("t1_we", {31'h0, wbm_we_o}, 32'h1);
    chk("t1_adr", wbm_adr_o, 32'h3003_0004);
    chk("t1_dat", wbm_dat_o, 32'h0001_2345);
    chk("t1_sel", {28'h0, wbm_sel_o}, 32'hF);
    chk("t1_cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
    chk("t1_state_bus", {30'h0, dbg_state}, {30'h0, ST_BUS});
    wait_rsp(40, k);
    chk("t1_rsp_latency", k, 3);
    chk("t1_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chk("t1_stb_cycles", stb_total - s0, 2);
    chk("t1_bus_quiet_adr", wbm_adr_o, 32'h0);
    chk("t1_bus_quiet_we", {31'h0, wbm_we_o}, 32'h0);
    @(negedge clk);
    chk("t1_cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
    chk("t1_rsp_done", {31'h0, rsp_valid}, 32'h0);

    // 2. Reads of the register window
    exp_q.push_back(32'h0001_2345);
    xact(1'b0, 32'h3003_0004, 32'h0, 4'hF, rd, er, k);
    chk("t2_gonso_rdata", rd, exp_q.pop_front());
    chk("t2_gonso_err", {31'h0, er}, 32'h0);
    xact(1'b1, 32'h3003_000C, 32'hDEAD_BEEF, 4'hF, rd, er, k);
    chk("t2_color_wr_rdata", rd, 32'h0);
    exp_q.push_back(32'h0000_00EF);
    xact(1'b0, 32'h3003_000C, 32'h0, 4'hF, rd, er, k);
    chk("t2_color_rdata", rd, exp_q.pop_front());
    xact(1'b1, 32'h3003_0008, 32'hCAFE_0001, 4'b0011, rd, er, k);
    exp_q.push_back(32'h0000_0001);
    xact(1'b0, 32'h3003_0008, 32'h0, 4'hF, rd, er, k);
    chk("t2_plus_sel_rdata", rd, exp_q.pop_front());

    // 3a. Slave never acks: one timeout
    slv_lat = 0;
    s0 = stb_total;
    send(1'b0, 32'h3003_0004, 32'h0, 4'hF);
    wait_rsp(40, k);
    chk("t3_stb_cycles", stb_total - s0, 16);
    chk("t3_rsp_latency", k, 17);
    chk("t3_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("t3_rsp_rdata", rsp_rdata, 32'h0);
    chk("t3_err_count", {24'h0, err_count}, 32'h1);
    chk("t3_cyc_dropped", {31'h0, wbm_cyc_o}, 32'h0);
    @(negedge clk);

    // 4. Ack latency 15 and 16 (ack on the timeout cycle)
    slv_lat = 15;
    xact(1'b0, 32'h3003_0004, 32'h0, 4'hF, rd, er, k);
    chk("t4_l15_err", {31'h0, er}, 32'h0);
    chk("t4_l15_rdata", rd, 32'h0001_2345);
    chk("t4_l15_latency", k, 16);
    slv_lat = 16;
    xact(1'b0, 32'h3003_0004, 32'h0, 4'hF, rd, er, k);
    chk("t4_l16_err", {31'h0, er}, 32'h0);
    chk("t4_l16_rdata", rd, 32'h0001_2345);
    chk("t4_l16_latency", k, 17);
    chk("t4_err_count", {24'h0, err_count}, 32'h1);

    // 3b. Timeouts up to saturation (300 in total)
    slv_lat = 0;
    for (int i = 1; i < 300; i++) begin
      xact(1'b0, 32'h3003_0008, 32'h0, 4'hF, rd, er, k);
      if (i == 253) chk("t3_err_count_254", {24'h0, err_count}, 32'd254);
    end
    chk("t3_err_count_sat", {24'h0, err_count}, 32'hFF);
    chk("t3_last_err", {31'h0, er}, 32'h1);

    // 5. Response back-pressure, blocked command, stray acks
    slv_lat = 2;
    rsp_ready = 1'b0;
    send(1'b0, 32'h3003_0004, 32'h0, 4'hF);
    wait_rsp(40, k);
    hold_rd = 32'h0001_2345;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        cmd_we = 1'b1; cmd_addr = 32'h3003_0004; cmd_wdata = 32'h5555_AAAA; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
      end
      stray_ack = (i == 4);
      @(negedge clk);
      chk("t5_rsp_valid_hold", {31'h0, rsp_valid}, 32'h1);
      chk("t5_rsp_rdata_hold", rsp_rdata, hold_rd);
      chk("t5_rsp_err_hold", {31'h0, rsp_err}, 32'h0);
      chk("t5_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
      chk("t5_no_bus", {31'h0, wbm_cyc_o}, 32'h0);
    end
    stray_ack = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_rsp_consumed", {31'h0, rsp_valid}, 32'h0);
    chk("t5_idle_ready", {31'h0, cmd_ready}, 32'h1);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("t5_idle_stray_no_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("t5_idle_stray_no_bus", {31'h0, wbm_cyc_o}, 32'h0);
    chk("t5_idle_stray_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});

    // 6. Reset while strobe is high
    slv_lat = 0;
    send(1'b0, 32'h3003_0004, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    chk("t6_stb_before", {31'h0, wbm_stb_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    chk("t6_rst_stb", {31'h0, wbm_stb_o}, 32'h0);
    chk("t6_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("t6_rst_err_count", {24'h0, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("t6_no_rsp", {31'h0, rsp_valid}, 32'h0);
    slv_lat = 2;
    xact(1'b0, 32'h3003_0004, 32'h0, 4'hF, rd, er, k);
    chk("t6_read_rdata", rd, 32'h0001_2345);
    chk("t6_read_err", {31'h0, er}, 32'h0);
    chk("t6_read_latency", k, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
